// File: rtl/flash_reader.sv
// flash_reader: SPI master issuing 0x03 reads to a serial flash and streaming bytes over valid/ready.
module flash_reader #(
  parameter int          CountBitWidth = 16,
  parameter logic [7:0]  ReadCommand   = 8'h03,
  parameter int          CsHighCycles  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [23:0]              address,
  input  logic [CountBitWidth-1:0] count,
  output logic                     busy,
  output logic [7:0]               data,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     done,
  output logic                     flash_clk,
  output logic                     flash_cs_n,
  output logic                     flash_mosi,
  input  logic                     flash_miso
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, REC} state_e;
  localparam int RcW = $clog2(CsHighCycles + 1);
  localparam logic [RcW-1:0] RcLast = RcW'(CsHighCycles - 1);
  localparam logic [CountBitWidth-1:0] One = 1;
  state_e state_q, state_d;
  logic sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic pend_q, pend_d, valid_q, valid_d, done_q, done_d;
  logic [4:0] bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d, data_q, data_d;
  logic [CountBitWidth-1:0] rem_q, rem_d;
  logic [RcW-1:0] rc_q, rc_d;
  logic accept, shifting, rise, fall, bit_last, byte_done, can_load, load, last_load, rec_done;
  assign accept    = state_q == IDLE && start;
  assign shifting  = (state_q == CMD || state_q == ADDR || state_q == DATA) && !pend_q;
  assign rise      = shifting && !sck_q;
  assign fall      = shifting && sck_q;
  assign bit_last  = bit_q == (state_q == ADDR ? 5'd23 : 5'd7);
  assign byte_done = fall && bit_last && state_q == DATA;
  assign can_load  = !valid_q || data_ready;
  // A completed byte waits in rx_q (clock paused) until the holding register frees up
  assign load      = (byte_done || pend_q) && can_load;
  assign last_load = load && rem_q == (pend_q ? '0 : One);
  assign rec_done  = state_q == REC && rc_q == RcLast && can_load;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (count == '0) ? REC : CMD;
      CMD:     if (fall && bit_last) state_d = ADDR;
      ADDR:    if (fall && bit_last) state_d = DATA;
      DATA:    if (last_load) state_d = REC;
      REC:     if (rec_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy       = state_q != IDLE;
    data       = data_q;
    data_valid = valid_q;
    done       = done_q;
    flash_clk  = sck_q;
    flash_cs_n = cs_n_q;
    flash_mosi = mosi_q;
  end
  always_comb begin
    sck_d   = rise;
    mosi_d  = rise ? tx_q[31] : mosi_q;
    bit_d   = accept ? 5'd0 : fall ? (bit_last ? 5'd0 : bit_q + 5'd1) : bit_q;
    tx_d    = accept ? {ReadCommand, address} : fall ? {tx_q[30:0], 1'b0} : tx_q;
    rx_d    = rise ? {rx_q[6:0], flash_miso} : rx_q;
    rem_d   = accept ? count : byte_done ? rem_q - One : rem_q;
    pend_d  = (byte_done || pend_q) && !can_load;
    data_d  = load ? rx_q : data_q;
    valid_d = load || (valid_q && !data_ready);
    cs_n_d  = accept ? (count == '0) : last_load ? 1'b1 : cs_n_q;
    rc_d    = state_q != REC ? '0 : (rc_q == RcLast ? rc_q : rc_q + 1'b1);
    done_d  = rec_done;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      rc_q    <= '0;
    end else begin
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      rc_q    <= rc_d;
    end
  end
endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader: randomized scoreboard bench with a behavioural SPI flash model.
module tb_flash_reader;
  localparam int CS = 4;
  logic clk = 1'b0;
  logic rst_n, start, busy, data_valid, data_ready, done;
  logic flash_clk, flash_cs_n, flash_mosi, flash_miso;
  logic [23:0] address;
  logic [15:0] count;
  logic [7:0] data;
  int checks = 0, errors = 0;
  int fclk_edges = 0, cs_rises = 0, done_cnt = 0;
  int rmode = 0;
  logic [7:0] ovr [int];
  logic [7:0] exp_q [$];
  logic [31:0] exp_addr_q [$];

  always #5 clk = ~clk;

  flash_reader #(.CountBitWidth(16), .ReadCommand(8'h03), .CsHighCycles(CS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .address(address), .count(count),
    .busy(busy), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .done(done), .flash_clk(flash_clk), .flash_cs_n(flash_cs_n),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return ovr.exists(int'(a)) ? ovr[int'(a)] : (a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A) + 8'd17;
  endfunction

  always @(flash_clk) fclk_edges++;
  always @(posedge flash_cs_n) cs_rises++;

  // Flash device: samples mosi on falling sck, launches read data on falling sck
  initial begin
    int nb;
    logic [31:0] sh;
    logic [23:0] fa;
    logic [7:0] b;
    flash_miso = 1'b0;
    fa = '0;
    forever begin
      @(negedge flash_cs_n);
      nb = 0;
      sh = '0;
      while (!flash_cs_n) begin
        @(negedge flash_clk or posedge flash_cs_n);
        if (flash_cs_n) break;
        if (nb < 32) begin
          sh = {sh[30:0], flash_mosi};
          nb++;
          if (nb == 32) begin
            check("cmd_addr", sh, exp_addr_q.size() != 0 ? exp_addr_q.pop_front() : 32'hFFFF_FFFF);
            fa = sh[23:0];
          end
        end
        if (nb >= 32) begin
          b = mem_byte(fa + 24'((nb - 32) / 8));
          flash_miso = b[3'(7 - (nb - 32) % 8)];
          nb++;
        end
      end
    end
  end

  // Consumer: always ready, random ready, or 20-cycle stall per byte
  initial begin
    int h;
    bit pv;
    data_ready = 1'b1;
    h = 0;
    pv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pv && data_ready) h = 0;
      if (rmode == 0) data_ready = 1'b1;
      else if (rmode == 1) data_ready = 1'($urandom_range(0, 1));
      else if (data_valid && h < 20) begin data_ready = 1'b0; h++; end
      else data_ready = data_valid;
      pv = data_valid;
    end
  end

  // Monitor: pops expected bytes on every handshake and checks output hold stability
  initial begin
    bit hv;
    logic [7:0] hd;
    hv = 1'b0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (hv) check("hold_stable", 32'({data_valid, data}), 32'({1'b1, hd}));
      hv = rst_n && data_valid && !data_ready;
      hd = data;
      if (rst_n && data_valid && data_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
        else check("byte", 32'(data), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic xfer(input logic [23:0] a, input logic [15:0] n, input bit poke);
    int e_edges, e_cs, e_done, lat, dur;
    bit cs_low;
    @(posedge clk); #1;
    start = 1'b1;
    address = a;
    count = n;
    if (n != 0) exp_addr_q.push_back({8'h03, a});
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_byte(a + 24'(i)));
    @(posedge clk);
    e_edges = fclk_edges;
    e_cs = cs_rises;
    e_done = done_cnt;
    #1 start = 1'b0;
    lat = -1;
    dur = -1;
    cs_low = 1'b0;
    for (int c = 1; c < 20000; c++) begin
      if (c == 1) check("busy_e1", 32'(busy), 32'd1);
      if (poke && c == 40) begin start = 1'b1; address = 24'h0ABCDE; count = 16'd3; end
      if (poke && c == 41) start = 1'b0;
      if (!flash_cs_n) cs_low = 1'b1;
      if (data_valid && lat < 0) lat = c;
      if (done) begin dur = c; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", 32'(dur > 0), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    if (n != 0) check("first_valid_cycle", 32'(lat), 32'd81);
    if (rmode == 0) check("done_cycle", 32'(dur), n == 0 ? 32'(CS + 1) : 32'(64 + 16 * int'(n) + CS + 1));
    check("cs_low_seen", 32'(cs_low), 32'(n != 0));
    @(posedge clk); #1;
    check("done_single", 32'(done_cnt - e_done), 32'd1);
    check("sck_edges", 32'(fclk_edges - e_edges), n == 0 ? 32'd0 : 32'(64 + 16 * int'(n)));
    check("cs_rises", 32'(cs_rises - e_cs), 32'(n != 0));
  endtask

  initial begin
    int e_done;
    rst_n = 1'b0;
    start = 1'b0;
    address = '0;
    count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(flash_cs_n), 32'd1);
    check("rst_sck", 32'(flash_clk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_mosi", 32'({data, flash_mosi}), 32'd0);
    rst_n = 1'b1;
    ovr[16] = 8'hA5;
    for (int i = 0; i < 16; i++) ovr[32 + i] = 8'(i);
    xfer(24'h000010, 16'd1, 1'b0);
    xfer(24'h000020, 16'd16, 1'b1);
    rmode = 2;
    xfer(24'h000100, 16'd4, 1'b0);
    rmode = 0;
    xfer(24'h000055, 16'd0, 1'b0);
    // Abort in the middle of the address phase
    @(posedge clk); #1;
    start = 1'b1;
    address = 24'h123456;
    count = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    e_done = done_cnt;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_cs_n", 32'(flash_cs_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sck", 32'(flash_clk), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("abort_no_done", 32'(done_cnt - e_done), 32'd0);
    xfer(24'h000010, 16'd1, 1'b0);
    rmode = 1;
    for (int k = 0; k < 6; k++)
      xfer(k == 0 ? 24'hFFFFFD : 24'($urandom), 16'($urandom_range(1, 6)), 1'b0);
    rmode = 0;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
